bitonic_s3_pipe: RTL and testbench
==================================

BITONIC_S3_PIPE -- requirements
Module: bitonic_s3_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the unsigned bit width of each number.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, meaning an input vector is presented.
REQ-005 SHALL have port in_ready, output, 1, meaning the block accepts the input this cycle.
REQ-006 SHALL have ports number_in1..number_in8, input, WIDTH each, carrying the bitonic vector from the stage-2 sorter: in1..in4 ascending, in5..in8 descending.
REQ-007 SHALL have port out_valid, output, 1, meaning the sorted vector is presented.
REQ-008 SHALL have port out_ready, input, 1, meaning the consumer accepts the output this cycle.
REQ-009 SHALL have ports number_out1..number_out8, output, WIDTH each, carrying the vector sorted ascending (out1 smallest).
REQ-010 SHALL have port err_out, output, 1, flagging a non-bitonic input; it is qualified by out_valid.

Function
REQ-011 SHALL count an input transfer when in_valid and in_ready are both 1 on a rising edge, and an output transfer when out_valid and out_ready are both 1.
REQ-012 SHALL implement three registered compare-exchange layers, A, B and C, each with its own valid bit.
REQ-013 Layer A SHALL compare pairs (1,5), (2,6), (3,7) and (4,8).
REQ-014 Layer B SHALL compare pairs (1,3), (2,4), (5,7) and (6,8).
REQ-015 Layer C SHALL compare pairs (1,2), (3,4), (5,6) and (7,8).
REQ-016 Every compare-exchange SHALL be ascending, placing the minimum at the lower index; comparison is unsigned.
REQ-017 On equal operands, a compare-exchange SHALL pass both values unchanged.
REQ-018 Latency SHALL be exactly 3 cycles from input transfer to out_valid=1 when there is no stall.
REQ-019 Throughput SHALL be one vector per cycle when there is no stall.
REQ-020 stall SHALL be defined as out_valid AND NOT out_ready.
REQ-021 in_ready SHALL equal NOT stall, combinationally.
REQ-022 While stall=1, all layer data and valid registers SHALL hold their values.
REQ-023 While stall=1, number_out*, err_out and out_valid SHALL stay stable.
REQ-024 While stall=0, each layer SHALL load from its predecessor; layer A loads the input and sets valid_A to in_valid.
REQ-025 A bubble (predecessor valid=0) SHALL propagate as valid=0, and the data registers MAY update.
REQ-026 err flag: at input transfer, err SHALL be set if in1>in2, in2>in3 or in3>in4, or if in5<in6, in6<in7 or in7<in8.
REQ-027 The err flag SHALL travel with its vector and appear on err_out; data SHALL still be processed normally.
REQ-028 out_valid SHALL be the layer C valid bit; number_out* and err_out SHALL come directly from layer C registers.
REQ-029 in_valid=1 while in_ready=0 SHALL NOT be captured; upstream holds the vector.

Reset
REQ-030 On rst_n=0, all valid bits SHALL clear to 0 immediately, giving out_valid=0 and in_ready=1.
REQ-031 On rst_n=0, all data registers and err bits SHALL clear to 0, so number_out1..8=0 and err_out=0.
REQ-032 Vectors in flight when reset asserts SHALL be discarded.
REQ-033 The first input transfer after rst_n deasserts SHALL produce out_valid on the 3rd following edge.

Verification
REQ-034 Bench SHALL cover: in=3,7,9,12,20,15,5,1, out_ready=1 -> 3 cycles later out=1,3,5,7,9,12,15,20, err_out=0.
REQ-035 Bench SHALL cover: in=5,5,5,5,5,5,5,5 -> out all 5, err_out=0; also in=0,0,255,255,255,255,0,0 (WIDTH=8) -> out=0,0,0,0,255,255,255,255.
REQ-036 Bench SHALL cover: four back-to-back vectors, out_ready=1 -> out_valid high 4 consecutive cycles starting cycle 3, in order.
REQ-037 Bench SHALL cover: out_ready=0 for 5 cycles with 3 vectors in flight -> in_ready=0, outputs frozen on the first vector, none lost or duplicated after release.
REQ-038 Bench SHALL cover: in=9,3,4,5,8,7,6,2 (non-bitonic) -> err_out=1 with out_valid; unflagged vectors before and after -> err_out=0.
REQ-039 Bench SHALL cover: rst_n pulsed low with 2 vectors in flight -> out_valid=0 and outputs 0 asynchronously, neither vector ever emitted.

Source files
------------

// File: rtl/bitonic_s3_pipe.sv
// Final merge stage of an 8-input bitonic sorter: three registered
// compare-exchange layers (A, B, C) behind a valid/ready handshake.
// A global stall freezes every layer while the output is back-pressured.

// One ascending compare-exchange: min goes low, max goes high.
// Equal operands pass through unchanged.
module bitonic_s3_cx #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);
  logic swap;
  assign swap = a_i > b_i;
  assign lo_o = swap ? b_i : a_i;
  assign hi_o = swap ? a_i : b_i;
endmodule

module bitonic_s3_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] number_in1,
  input  logic [WIDTH-1:0] number_in2,
  input  logic [WIDTH-1:0] number_in3,
  input  logic [WIDTH-1:0] number_in4,
  input  logic [WIDTH-1:0] number_in5,
  input  logic [WIDTH-1:0] number_in6,
  input  logic [WIDTH-1:0] number_in7,
  input  logic [WIDTH-1:0] number_in8,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] number_out1,
  output logic [WIDTH-1:0] number_out2,
  output logic [WIDTH-1:0] number_out3,
  output logic [WIDTH-1:0] number_out4,
  output logic [WIDTH-1:0] number_out5,
  output logic [WIDTH-1:0] number_out6,
  output logic [WIDTH-1:0] number_out7,
  output logic [WIDTH-1:0] number_out8,
  output logic             err_out
);
  localparam int NUM_LANES = 8;
  localparam int STAGES    = 3;

  typedef struct packed {
    logic [NUM_LANES-1:0][WIDTH-1:0] d;
    logic                            err;
  } stage_t;

  logic [NUM_LANES-1:0][WIDTH-1:0] din, a_d, b_d, c_d;
  stage_t                          a_q, b_q, c_q;
  logic [STAGES:1]                 vld_pipe_q;
  logic                            stall, err_d;

  assign din = {number_in8, number_in7, number_in6, number_in5,
                number_in4, number_in3, number_in2, number_in1};

  // Lower half must be ascending and upper half descending; anything
  // else still sorts through the network but is tagged as an error.
  assign err_d = (din[0] > din[1]) || (din[1] > din[2]) || (din[2] > din[3]) ||
                 (din[4] < din[5]) || (din[5] < din[6]) || (din[6] < din[7]);

  assign stall    = vld_pipe_q[STAGES] & ~out_ready;
  assign in_ready = ~stall;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cx
      // A: distance 4, B: distance 2 within each half, C: distance 1
      bitonic_s3_cx #(.WIDTH(WIDTH)) u_a (
        .a_i (din[gi]),               .b_i (din[gi+4]),
        .lo_o(a_d[gi]),               .hi_o(a_d[gi+4]));
      bitonic_s3_cx #(.WIDTH(WIDTH)) u_b (
        .a_i (a_q.d[(gi/2)*4+gi%2]),  .b_i (a_q.d[(gi/2)*4+gi%2+2]),
        .lo_o(b_d[(gi/2)*4+gi%2]),    .hi_o(b_d[(gi/2)*4+gi%2+2]));
      bitonic_s3_cx #(.WIDTH(WIDTH)) u_c (
        .a_i (b_q.d[2*gi]),           .b_i (b_q.d[2*gi+1]),
        .lo_o(c_d[2*gi]),             .hi_o(c_d[2*gi+1]));
    end
  endgenerate

  // Pipeline advance: all layers move together unless the output stalls.
  // Bubbles carry data too; only the valid bit matters for them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
    end else if (!stall) begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], in_valid};
      a_q        <= '{d: a_d, err: err_d};
      b_q        <= '{d: b_d, err: a_q.err};
      c_q        <= '{d: c_d, err: b_q.err};
    end
  end

  assign out_valid   = vld_pipe_q[STAGES];
  assign err_out     = c_q.err;
  assign number_out1 = c_q.d[0];
  assign number_out2 = c_q.d[1];
  assign number_out3 = c_q.d[2];
  assign number_out4 = c_q.d[3];
  assign number_out5 = c_q.d[4];
  assign number_out6 = c_q.d[5];
  assign number_out7 = c_q.d[6];
  assign number_out8 = c_q.d[7];
endmodule

// File: tb/tb_bitonic_s3_pipe.sv
// Directed bench for bitonic_s3_pipe: table of hand-sorted vectors plus
// back-to-back, stall, error-tag and mid-flight reset sequences.
module tb_bitonic_s3_pipe;
  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready, out_valid, out_ready, err_out;
  logic [7:0][7:0] din, dout;
  logic [7:0] o1, o2, o3, o4, o5, o6, o7, o8;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign dout = {o8, o7, o6, o5, o4, o3, o2, o1};

  bitonic_s3_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .number_in1(din[0]), .number_in2(din[1]), .number_in3(din[2]), .number_in4(din[3]),
    .number_in5(din[4]), .number_in6(din[5]), .number_in7(din[6]), .number_in8(din[7]),
    .out_valid(out_valid), .out_ready(out_ready),
    .number_out1(o1), .number_out2(o2), .number_out3(o3), .number_out4(o4),
    .number_out5(o5), .number_out6(o6), .number_out7(o7), .number_out8(o8),
    .err_out(err_out));

  typedef struct {
    logic [7:0][7:0] din;
    logic [7:0][7:0] dout;
    logic            err;
  } vec_t;

  vec_t tbl[7];

  function automatic logic [7:0][7:0] p8(int a0, int a1, int a2, int a3,
                                         int a4, int a5, int a6, int a7);
    logic [7:0][7:0] r;
    r[0] = 8'(a0); r[1] = 8'(a1); r[2] = 8'(a2); r[3] = 8'(a3);
    r[4] = 8'(a4); r[5] = 8'(a5); r[6] = 8'(a6); r[7] = 8'(a7);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tk();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input vec_t v);
    chk({nm, ".valid"}, 64'(out_valid), 64'd1);
    chk({nm, ".data"},  dout, v.dout);
    chk({nm, ".err"},   64'(err_out), 64'(v.err));
  endtask

  initial begin
    vec_t q[$];
    vec_t seq[4];
    int   n;

    tbl[0] = '{p8(3,7,9,12,20,15,5,1),        p8(1,3,5,7,9,12,15,20),       1'b0};
    tbl[1] = '{p8(5,5,5,5,5,5,5,5),           p8(5,5,5,5,5,5,5,5),          1'b0};
    tbl[2] = '{p8(0,0,255,255,255,255,0,0),   p8(0,0,0,0,255,255,255,255),  1'b0};
    tbl[3] = '{p8(9,3,4,5,8,7,6,2),           p8(2,4,3,8,5,6,7,9),          1'b1};
    tbl[4] = '{p8(10,20,30,40,35,25,15,5),    p8(5,10,15,20,25,30,35,40),   1'b0};
    tbl[5] = '{p8(1,2,3,4,8,7,6,5),           p8(1,2,3,4,5,6,7,8),          1'b0};
    tbl[6] = '{p8(0,1,2,3,4,5,6,7),           p8(0,1,2,3,4,5,6,7),          1'b1};

    in_valid = 1'b0; out_ready = 1'b1; din = '0; rst_n = 1'b0;
    #12;
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.in_ready",  64'(in_ready),  64'd1);
    chk("rst.data",      dout,           64'd0);
    chk("rst.err",       64'(err_out),   64'd0);
    rst_n = 1'b1;
    tk();

    // Single vectors: out_valid must appear exactly three edges after presentation
    foreach (tbl[i]) begin
      din = tbl[i].din; in_valid = 1'b1;
      tk();
      in_valid = 1'b0; din = '0;
      tk();
      chk($sformatf("lat%0d.early", i), 64'(out_valid), 64'd0);
      tk();
      chk_out($sformatf("vec%0d", i), tbl[i]);
      tk();
    end

    // Back-to-back: four vectors, four consecutive output cycles in order
    seq[0] = tbl[0]; seq[1] = tbl[1]; seq[2] = tbl[4]; seq[3] = tbl[5];
    for (int t = 0; t < 9; t++) begin
      in_valid = (t < 4);
      din      = (t < 4) ? seq[t].din : '0;
      if (t >= 3 && t <= 6) chk_out($sformatf("b2b%0d", t), seq[t-3]);
      else chk($sformatf("b2b%0d.valid", t), 64'(out_valid), 64'd0);
      tk();
    end

    // Stall: three in flight, consumer blocks for five cycles, a fourth
    // vector waits upstream and must not enter until released
    seq[0] = tbl[0]; seq[1] = tbl[4]; seq[2] = tbl[5];
    for (int t = 0; t < 3; t++) begin
      in_valid = 1'b1; din = seq[t].din;
      tk();
    end
    in_valid = 1'b1; din = tbl[1].din; out_ready = 1'b0;
    for (int t = 0; t < 5; t++) begin
      #1;
      chk($sformatf("stall%0d.in_ready", t), 64'(in_ready), 64'd0);
      chk_out($sformatf("stall%0d", t), tbl[0]);
      tk();
    end
    out_ready = 1'b1;
    #1;
    chk("release.in_ready", 64'(in_ready), 64'd1);
    q.delete();
    for (int t = 0; t < 8; t++) begin
      if (out_valid) q.push_back('{din: '0, dout: dout, err: err_out});
      tk();
      in_valid = 1'b0; din = '0;
    end
    chk("stall.count", 64'(q.size()), 64'd4);
    seq[3] = tbl[1];
    n = (q.size() < 4) ? q.size() : 4;
    for (int k = 0; k < n; k++) chk($sformatf("stall.order%0d", k), q[k].dout, seq[k].dout);

    // Error tag travels with its own vector only
    seq[0] = tbl[5]; seq[1] = tbl[3]; seq[2] = tbl[4];
    for (int t = 0; t < 6; t++) begin
      in_valid = (t < 3);
      din      = (t < 3) ? seq[t].din : '0;
      if (t >= 3) chk_out($sformatf("errseq%0d", t), seq[t-3]);
      tk();
    end

    // Reset with two vectors in flight: cleared at once, never emitted
    in_valid = 1'b1; din = tbl[0].din;
    tk();
    din = tbl[4].din;
    tk();
    in_valid = 1'b0; din = '0;
    tk();
    chk("pre_rst.valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.out_valid", 64'(out_valid), 64'd0);
    chk("arst.in_ready",  64'(in_ready),  64'd1);
    chk("arst.data",      dout,           64'd0);
    chk("arst.err",       64'(err_out),   64'd0);
    tk();
    rst_n = 1'b1;
    n = 0;
    for (int t = 0; t < 6; t++) begin
      tk();
      if (out_valid) n++;
    end
    chk("arst.no_emit", 64'(n), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
